mirfak_pipeline_ctrl_sb: RTL and testbench



---
 rtl/mirfak_pipeline_ctrl_sb_if.sv | 34 +++
 rtl/mirfak_pipeline_ctrl_sb.sv | 87 ++++++++
 tb/tb_mirfak_pipeline_ctrl_sb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mirfak_pipeline_ctrl_sb_if.sv
// mirfak_pipeline_ctrl_sb_if: ID operands, forwarding sources, long-latency writeback and stage status/control
interface mirfak_pipeline_ctrl_sb_if #(
  parameter int NUM_FWD = 2,
  parameter int CNT_W = 16
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  logic [4:0] id_rs1_i, id_rs2_i, id_wa_i;
  logic id_wen_i, id_lrl_i;
  logic [5*NUM_FWD-1:0] fwd_wa_i;
  logic [NUM_FWD-1:0] fwd_wen_i, fwd_late_i;
  logic [SELW-1:0] id_fwd_a_sel_o, id_fwd_b_sel_o;
  logic lrl_done_i;
  logic [4:0] lrl_wa_i;
  logic lrl_kill_o;
  logic wb_busy_i, ex_busy_i, id_busy_i, if_ready_i;
  logic wb_exception_i, wb_xret_i, id_bj_taken_i;
  logic exwb_enable_o, exwb_clear_o, idex_enable_o, idex_clear_o, ifid_enable_o, ifid_clear_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic sb_error_o;
  modport slave (
    input id_rs1_i, id_rs2_i, id_wa_i, id_wen_i, id_lrl_i, fwd_wa_i, fwd_wen_i, fwd_late_i,
          lrl_done_i, lrl_wa_i, wb_busy_i, ex_busy_i, id_busy_i, if_ready_i,
          wb_exception_i, wb_xret_i, id_bj_taken_i,
    output id_fwd_a_sel_o, id_fwd_b_sel_o, lrl_kill_o, exwb_enable_o, exwb_clear_o,
           idex_enable_o, idex_clear_o, ifid_enable_o, ifid_clear_o, stall_cnt_o, sb_error_o
  );
  modport master (
    output id_rs1_i, id_rs2_i, id_wa_i, id_wen_i, id_lrl_i, fwd_wa_i, fwd_wen_i, fwd_late_i,
           lrl_done_i, lrl_wa_i, wb_busy_i, ex_busy_i, id_busy_i, if_ready_i,
           wb_exception_i, wb_xret_i, id_bj_taken_i,
    input id_fwd_a_sel_o, id_fwd_b_sel_o, lrl_kill_o, exwb_enable_o, exwb_clear_o,
          idex_enable_o, idex_clear_o, ifid_enable_o, ifid_clear_o, stall_cnt_o, sb_error_o
  );
endinterface

// File: rtl/mirfak_pipeline_ctrl_sb.sv
// mirfak_pipeline_ctrl_sb: 4-stage pipeline enables/clears, operand forwarding and long-latency scoreboard
module mirfak_pipeline_ctrl_sb #(
  parameter int NUM_FWD = 2,
  parameter int MAX_PENDING = 2,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  mirfak_pipeline_ctrl_sb_if.slave bus
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  localparam int PCW = $clog2(MAX_PENDING + 1);
  logic [31:0] busy_q, busy_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [SELW-1:0] sel_a, sel_b;
  logic late_a, late_b, late, sb_hazard, flush;
  logic wb_ready, ex_ready, id_ready, if_ready, issue, done_hit;
  // descending scan so the youngest matching source has the final say
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    late_a = 1'b0;
    late_b = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (bus.id_rs1_i != 5'd0 && bus.id_rs1_i == bus.fwd_wa_i[5*k +: 5] && bus.fwd_wen_i[k]) begin
        sel_a = SELW'(k + 1);
        late_a = bus.fwd_late_i[k];
      end
      if (bus.id_rs2_i != 5'd0 && bus.id_rs2_i == bus.fwd_wa_i[5*k +: 5] && bus.fwd_wen_i[k]) begin
        sel_b = SELW'(k + 1);
        late_b = bus.fwd_late_i[k];
      end
    end
  end
  assign late = late_a || late_b;
  assign sb_hazard = busy_q[bus.id_rs1_i] || busy_q[bus.id_rs2_i] ||
                     (bus.id_wen_i && busy_q[bus.id_wa_i]) ||
                     (bus.id_lrl_i && pc_q == PCW'(MAX_PENDING));
  assign flush = bus.wb_exception_i || bus.wb_xret_i;
  assign wb_ready = !bus.wb_busy_i;
  assign ex_ready = wb_ready && !bus.ex_busy_i;
  assign id_ready = ex_ready && !bus.id_busy_i && !late && !sb_hazard;
  assign if_ready = id_ready && bus.if_ready_i;
  assign bus.id_fwd_a_sel_o = sel_a;
  assign bus.id_fwd_b_sel_o = sel_b;
  assign bus.exwb_enable_o = ex_ready;
  assign bus.idex_enable_o = id_ready;
  assign bus.ifid_enable_o = if_ready;
  assign bus.exwb_clear_o = (!ex_ready && wb_ready) || flush;
  assign bus.idex_clear_o = (!id_ready && ex_ready) || flush;
  assign bus.ifid_clear_o = (!if_ready && id_ready) || flush || bus.id_bj_taken_i;
  assign bus.lrl_kill_o = flush;
  assign bus.stall_cnt_o = cnt_q;
  assign bus.sb_error_o = err_q;
  assign issue = id_ready && !bus.idex_clear_o && bus.id_lrl_i && bus.id_wen_i && bus.id_wa_i != 5'd0;
  assign done_hit = bus.lrl_done_i && busy_q[bus.lrl_wa_i];
  // clear-then-set keeps a same-register issue/done pair busy with pc unchanged
  always_comb begin
    busy_d = busy_q;
    if (done_hit) busy_d[bus.lrl_wa_i] = 1'b0;
    if (issue) busy_d[bus.id_wa_i] = 1'b1;
    busy_d[0] = 1'b0;
    pc_d = pc_q + PCW'(issue) - PCW'(done_hit);
    err_d = err_q || (bus.lrl_done_i && !busy_q[bus.lrl_wa_i]);
    cnt_d = (ex_ready && (late || sb_hazard) && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    if (flush) begin
      busy_d = '0;
      pc_d = '0;
      err_d = err_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      pc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mirfak_pipeline_ctrl_sb.sv
// tb_mirfak_pipeline_ctrl_sb: directed plus random stimulus against a queue-based reference model, scoreboard-checked
module tb_mirfak_pipeline_ctrl_sb;
  localparam int NF = 3;
  localparam int MP = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic rst;
    logic [4:0] rs1, rs2, wa;
    logic wen, lrl;
    logic [5*NF-1:0] fwa;
    logic [NF-1:0] fwen, flate;
    logic done;
    logic [4:0] lwa;
    logic wbb, exb, idb, ifr, exc, xret, bj;
  } stim_t;
  typedef struct {
    logic [1:0] sel_a, sel_b;
    logic [5:0] ctl;
    logic kill;
    logic [CW-1:0] cnt;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t expq[$];
  int pend[$];
  int cnt = 0;
  bit err = 1'b0;
  mirfak_pipeline_ctrl_sb_if #(.NUM_FWD(NF), .CNT_W(CW)) bus ();
  mirfak_pipeline_ctrl_sb #(.NUM_FWD(NF), .MAX_PENDING(MP), .CNT_W(CW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("sel_a", 32'(bus.id_fwd_a_sel_o), 32'(e.sel_a));
      chk("sel_b", 32'(bus.id_fwd_b_sel_o), 32'(e.sel_b));
      chk("ctl{exwb_en,exwb_clr,idex_en,idex_clr,ifid_en,ifid_clr}",
          32'({bus.exwb_enable_o, bus.exwb_clear_o, bus.idex_enable_o, bus.idex_clear_o,
               bus.ifid_enable_o, bus.ifid_clear_o}), 32'(e.ctl));
      chk("lrl_kill", 32'(bus.lrl_kill_o), 32'(e.kill));
      chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(e.cnt));
      chk("sb_error", 32'(bus.sb_error_o), 32'(e.err));
    end
  end
  function automatic int find_pend(int r);
    foreach (pend[i]) if (pend[i] == r) return i;
    return -1;
  endfunction
  function automatic int fsel(logic [4:0] r, stim_t s);
    for (int k = 0; k < NF; k++)
      if (r != 0 && r == s.fwa[5*k +: 5] && s.fwen[k]) return k + 1;
    return 0;
  endfunction
  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ifr = 1'b1;
    return s;
  endfunction
  task automatic step(input stim_t s);
    exp_t e;
    int sa, sb, idx;
    bit late, sbh, wbr, exr, idr, ifr, flush;
    rst = s.rst;
    bus.id_rs1_i = s.rs1; bus.id_rs2_i = s.rs2; bus.id_wa_i = s.wa;
    bus.id_wen_i = s.wen; bus.id_lrl_i = s.lrl;
    bus.fwd_wa_i = s.fwa; bus.fwd_wen_i = s.fwen; bus.fwd_late_i = s.flate;
    bus.lrl_done_i = s.done; bus.lrl_wa_i = s.lwa;
    bus.wb_busy_i = s.wbb; bus.ex_busy_i = s.exb; bus.id_busy_i = s.idb; bus.if_ready_i = s.ifr;
    bus.wb_exception_i = s.exc; bus.wb_xret_i = s.xret; bus.id_bj_taken_i = s.bj;
    sa = fsel(s.rs1, s);
    sb = fsel(s.rs2, s);
    late = (sa != 0 && s.flate[sa-1]) || (sb != 0 && s.flate[sb-1]);
    sbh = find_pend(s.rs1) >= 0 || find_pend(s.rs2) >= 0 || (s.wen && find_pend(s.wa) >= 0) ||
          (s.lrl && pend.size() == MP);
    wbr = !s.wbb;
    exr = wbr && !s.exb;
    idr = exr && !s.idb && !late && !sbh;
    ifr = idr && s.ifr;
    flush = s.exc || s.xret;
    e.sel_a = 2'(sa);
    e.sel_b = 2'(sb);
    e.ctl = {exr, (!exr && wbr) || flush, idr, (!idr && exr) || flush, ifr, (!ifr && idr) || flush || s.bj};
    e.kill = flush;
    e.cnt = CW'(cnt);
    e.err = err;
    expq.push_back(e);
    if (s.rst) begin
      pend.delete();
      cnt = 0;
      err = 1'b0;
    end else begin
      if (exr && (late || sbh) && cnt < CMAX) cnt++;
      if (flush) pend.delete();
      else begin
        if (s.done) begin
          idx = find_pend(s.lwa);
          if (idx >= 0) pend.delete(idx);
          else err = 1'b1;
        end
        if (idr && s.lrl && s.wen && s.wa != 0) pend.push_back(int'(s.wa));
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] rreg();
    return ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
  endfunction
  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rst = ($urandom_range(149) == 0);
    s.rs1 = rreg(); s.rs2 = rreg(); s.wa = rreg();
    s.wen = $urandom_range(1); s.lrl = ($urandom_range(2) == 0);
    for (int k = 0; k < NF; k++) s.fwa[5*k +: 5] = rreg();
    s.fwen = NF'($urandom); s.flate = NF'($urandom_range(7) == 0 ? $urandom : 0);
    s.wbb = ($urandom_range(9) == 0); s.exb = ($urandom_range(9) == 0); s.idb = ($urandom_range(9) == 0);
    s.ifr = ($urandom_range(7) != 0);
    s.exc = ($urandom_range(39) == 0); s.xret = ($urandom_range(59) == 0); s.bj = ($urandom_range(7) == 0);
    s.done = !(s.exc || s.xret) && ($urandom_range(3) == 0);
    s.lwa = (pend.size() > 0 && $urandom_range(4) != 0) ? 5'(pend[$urandom_range(pend.size() - 1)]) : rreg();
    return s;
  endfunction
  initial begin
    stim_t s;
    bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_wa_i = '0; bus.id_wen_i = 0; bus.id_lrl_i = 0;
    bus.fwd_wa_i = '0; bus.fwd_wen_i = '0; bus.fwd_late_i = '0; bus.lrl_done_i = 0; bus.lrl_wa_i = '0;
    bus.wb_busy_i = 0; bus.ex_busy_i = 0; bus.id_busy_i = 0; bus.if_ready_i = 1;
    bus.wb_exception_i = 0; bus.wb_xret_i = 0; bus.id_bj_taken_i = 0;
    @(posedge clk);
    #1;
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    step(idle());
    // forwarding priority
    s = idle(); s.rs1 = 5; s.fwa = {5'd5, 5'd5, 5'd5}; s.fwen = 3'b111;
    step(s);
    s.fwen = 3'b110; step(s);
    s.fwen = 3'b100; step(s);
    s.rs1 = 0; s.fwen = 3'b111; step(s);
    // load-use stall
    s = idle(); s.rs2 = 7; s.fwa[4:0] = 7; s.fwen = 3'b001; s.flate = 3'b001;
    repeat (3) step(s);
    // scoreboard RAW with done at T and release at T+1
    s = idle(); s.lrl = 1; s.wen = 1; s.wa = 9; step(s);
    s = idle(); s.rs1 = 9; step(s); step(s);
    s.done = 1; s.lwa = 9; step(s);
    s.done = 0; step(s);
    // capacity
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.lrl = 1; s.wen = 1; s.wa = 3; step(s);
    s.wa = 4; step(s);
    s.wa = 6; step(s); step(s);
    s.done = 1; s.lwa = 3; step(s);
    s.done = 0; step(s);
    // done on a non-busy register; error is sticky
    s = idle(); s.done = 1; s.lwa = 8; step(s);
    s = idle(); step(s); step(s);
    // flush with two pending, then show they are gone
    s = idle(); s.exc = 1; step(s);
    s = idle(); s.rs1 = 4; s.rs2 = 6; step(s);
    s = idle(); s.rst = 1; step(s);
    // saturation
    s = idle(); s.rs2 = 7; s.fwa[4:0] = 7; s.fwen = 3'b001; s.flate = 3'b001;
    repeat (20) step(s);
    step(idle());
    repeat (3000) step(rand_stim());
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0 pending expectations", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
